// File: rtl/io_entry_ctrl.sv
// rtl/io_entry_ctrl.sv - front-panel instruction entry controller and seven-segment display driver
//
// Optional feature: IO_RESULT_TIMEOUT_EN enables the result-wait timeout and err flag.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   switch[3:0]              field value entry
//   button[3:0]              single-cycle pulses: [0] next/commit, [1] view, [2] back, [3] abort
//   result, result_valid     datapath result and qualifier
//   instr_ready              core accepts instruction
//   instr, instr_valid       assembled instruction offer
//   pst, field_idx, err      state code, current entry field, timeout flag
//   ssd_seg, ssd_anode       active-low segments and digit enables
module io_entry_ctrl #(
    parameter int NFIELD   = 4,
    parameter int RES_W    = 4,
    parameter int SCAN_DIV = 100000,
    parameter int TIMEOUT  = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            switch,
    input  logic [3:0]            button,
    input  logic [RES_W-1:0]      result,
    input  logic                  result_valid,
    input  logic                  instr_ready,
    output logic [4*NFIELD-1:0]   instr,
    output logic                  instr_valid,
    output logic [2:0]            pst,
    output logic [2:0]            field_idx,
    output logic                  err,
    output logic [6:0]            ssd_seg,
    output logic [NFIELD-1:0]     ssd_anode
);
    localparam int IW = 4 * NFIELD;
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [2:0] LAST = 3'(NFIELD - 1);
    localparam logic [3:0] RES_DIG = 4'((RES_W + 3) / 4);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [RES_W-1:0]  res_q;
    logic [IW-1:0]     res_ext;
    logic              view;
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        digit;
    logic              to_hit;

    // Priority-resolved button events: abort > commit > back > view.
    logic ev_abort, ev_next, ev_back, ev_view;
    assign ev_abort = button[3];
    assign ev_next  = button[0] & ~button[3];
    assign ev_back  = button[2] & ~button[3] & ~button[0];
    assign ev_view  = button[1] & ~button[3] & ~button[0] & ~button[2];

    assign pst = state;

`ifdef IO_RESULT_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    assign to_hit = (to_cnt == TO_LAST);
    assign err    = err_q;

    // Counter stays at zero outside WAIT, so every WAIT visit starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state != S_WAIT || to_hit)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            if (ev_abort)
                err_q <= 1'b0;
            else if (state == S_WAIT && !result_valid && to_hit)
                err_q <= 1'b1;
            else if (state == S_DONE && state_next != S_DONE)
                err_q <= 1'b0;
        end
    end
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (ev_abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (ev_next) state_next = S_ENTRY;
                S_ENTRY: begin
                    if (ev_next && field_idx == 3'd0)
                        state_next = S_ISSUE;
                    else if (ev_back && field_idx == LAST)
                        state_next = S_IDLE;
                end
                S_ISSUE: if (instr_ready) state_next = S_WAIT;
                S_WAIT: begin
                    // A result in the terminal cycle takes precedence over the timeout.
                    if (result_valid || to_hit)
                        state_next = S_DONE;
                end
                S_DONE:  if (ev_next) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr       <= '0;
            instr_valid <= 1'b0;
            field_idx   <= LAST;
            res_q       <= '0;
            view        <= 1'b0;
        end else begin
            instr_valid <= (state_next == S_ISSUE);
            if (ev_abort) begin
                instr     <= '0;
                field_idx <= LAST;
            end else begin
                case (state)
                    S_IDLE: if (ev_next) field_idx <= LAST;
                    S_ENTRY: begin
                        if (ev_next) begin
                            for (int k = 0; k < NFIELD; k++)
                                if (field_idx == 3'(k))
                                    instr[4*k +: 4] <= switch;
                            if (field_idx != 3'd0)
                                field_idx <= field_idx - 3'd1;
                        end else if (ev_back && field_idx != LAST) begin
                            field_idx <= field_idx + 3'd1;
                        end
                    end
                    S_WAIT: if (result_valid) res_q <= result;
                    default: ;
                endcase
            end

            if (state != S_DONE || state_next != S_DONE)
                view <= 1'b0;
            else if (ev_view)
                view <= ~view;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            digit    <= 3'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            digit    <= (digit == LAST) ? 3'd0 : digit + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
        return ~s;
    endfunction

    // Digit d shows field NFIELD-1-d, so the first-entered field is rightmost.
    logic [2:0] field_sel;
    logic [3:0] fld_nib, res_nib, nib;
    logic       blank;

    always_comb begin
        res_ext = '0;
        res_ext[RES_W-1:0] = res_q;
        field_sel = LAST - digit;
        fld_nib = 4'h0;
        res_nib = 4'h0;
        for (int k = 0; k < NFIELD; k++) begin
            if (field_sel == 3'(k)) fld_nib = instr[4*k +: 4];
            if (digit == 3'(k))     res_nib = res_ext[4*k +: 4];
        end
        nib   = 4'h0;
        blank = 1'b0;
        case (state)
            S_IDLE: nib = 4'h0;
            S_ENTRY: begin
                if (field_sel == field_idx)
                    nib = switch;
                else if (field_sel > field_idx)
                    nib = fld_nib;
                else
                    blank = 1'b1;
            end
            S_ISSUE, S_WAIT: nib = fld_nib;
            S_DONE: begin
                if (err)
                    nib = 4'hE;
                else if (view)
                    nib = fld_nib;
                else if ({1'b0, digit} < RES_DIG)
                    nib = res_nib;
                else
                    blank = 1'b1;
            end
            default: blank = 1'b1;
        endcase
        ssd_seg = blank ? 7'h7F : hex7(nib);
        for (int d = 0; d < NFIELD; d++)
            ssd_anode[d] = (digit != 3'(d));
    end
endmodule

// File: tb/tb_io_entry_ctrl.sv
// tb/tb_io_entry_ctrl.sv - self-checking bench for io_entry_ctrl
module tb_io_entry_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  switch;
    logic [3:0]  button;
    logic [3:0]  result;
    logic        result_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        instr_valid;
    logic [2:0]  pst;
    logic [2:0]  field_idx;
    logic        err;
    logic [6:0]  ssd_seg;
    logic [3:0]  ssd_anode;

    int checks = 0;
    int failures = 0;
    logic [6:0] disp [4];

    localparam logic [6:0] G_BLK = 7'h7F, G_0 = 7'h40, G_3 = 7'h30, G_5 = 7'h12,
                           G_6 = 7'h02, G_7 = 7'h78, G_9 = 7'h10, G_C = 7'h46, G_E = 7'h06;

    io_entry_ctrl #(.NFIELD(4), .RES_W(4), .SCAN_DIV(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .switch(switch), .button(button), .result(result),
        .result_valid(result_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_valid(instr_valid), .pst(pst), .field_idx(field_idx), .err(err),
        .ssd_seg(ssd_seg), .ssd_anode(ssd_anode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  btn;
        logic [3:0]  sw;
        logic        rdy;
        logic        rv;
        logic [3:0]  res;
        logic [2:0]  e_pst;
        logic [15:0] e_instr;
        logic        e_valid;
        logic [2:0]  e_fidx;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] b, input logic [3:0] s, input logic r, input logic v,
                       input logic [3:0] rs, input logic [2:0] p, input logic [15:0] i,
                       input logic iv, input logic [2:0] f);
        vec_t t;
        t.btn = b; t.sw = s; t.rdy = r; t.rv = v; t.res = rs;
        t.e_pst = p; t.e_instr = i; t.e_valid = iv; t.e_fidx = f;
        vq.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] b, input logic [3:0] s);
        switch = s;
        button = b;
        tick();
        button = 4'h0;
    endtask

    task automatic grab();
        logic [3:0] seen;
        seen = 4'h0;
        for (int c = 0; c < 16; c++) begin
            tick();
            case (ssd_anode)
                4'b1110: begin disp[0] = ssd_seg; seen[0] = 1'b1; end
                4'b1101: begin disp[1] = ssd_seg; seen[1] = 1'b1; end
                4'b1011: begin disp[2] = ssd_seg; seen[2] = 1'b1; end
                4'b0111: begin disp[3] = ssd_seg; seen[3] = 1'b1; end
                default: chk("anode_onehot", {28'h0, ssd_anode}, 32'hE);
            endcase
        end
        chk("anode_cover", {28'h0, seen}, 32'hF);
    endtask

    task automatic chk_disp(input string name, input logic [6:0] d0, input logic [6:0] d1,
                            input logic [6:0] d2, input logic [6:0] d3);
        grab();
        chk({name, "_d0"}, {25'h0, disp[0]}, {25'h0, d0});
        chk({name, "_d1"}, {25'h0, disp[1]}, {25'h0, d1});
        chk({name, "_d2"}, {25'h0, disp[2]}, {25'h0, d2});
        chk({name, "_d3"}, {25'h0, disp[3]}, {25'h0, d3});
    endtask

    initial begin
        rst = 1'b1; switch = 4'h0; button = 4'h0; result = 4'h0;
        result_valid = 1'b0; instr_ready = 1'b0;
        tick(); tick(); tick();
        chk("rst_pst", {29'h0, pst}, 32'd0);
        chk("rst_instr", {16'h0, instr}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'd0);
        chk("rst_fidx", {29'h0, field_idx}, 32'd3);
        chk("rst_err", {31'h0, err}, 32'd0);
        chk("rst_anode", {28'h0, ssd_anode}, 32'hE);
        chk("rst_seg", {25'h0, ssd_seg}, {25'h0, G_0});
        rst = 1'b0;

        //   btn    sw    rdy   rv    res   pst   instr     v     fidx
        add(4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 3'd1, 16'h0000, 1'b0, 3'd3);
        add(4'h1, 4'h3, 1'b0, 1'b0, 4'h0, 3'd1, 16'h3000, 1'b0, 3'd2);
        add(4'h5, 4'hA, 1'b0, 1'b0, 4'h0, 3'd1, 16'h3A00, 1'b0, 3'd1);
        add(4'h1, 4'h5, 1'b0, 1'b0, 4'h0, 3'd1, 16'h3A50, 1'b0, 3'd0);
        add(4'h1, 4'hC, 1'b0, 1'b0, 4'h0, 3'd2, 16'h3A5C, 1'b1, 3'd0);
        add(4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 3'd2, 16'h3A5C, 1'b1, 3'd0);
        add(4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 3'd3, 16'h3A5C, 1'b0, 3'd0);
        add(4'h9, 4'h0, 1'b0, 1'b0, 4'h0, 3'd0, 16'h0000, 1'b0, 3'd3);
        add(4'h0, 4'h0, 1'b0, 1'b1, 4'h9, 3'd0, 16'h0000, 1'b0, 3'd3);
        add(4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 3'd1, 16'h0000, 1'b0, 3'd3);
        add(4'h4, 4'h0, 1'b0, 1'b0, 4'h0, 3'd0, 16'h0000, 1'b0, 3'd3);
        add(4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 3'd1, 16'h0000, 1'b0, 3'd3);
        add(4'h1, 4'h3, 1'b0, 1'b0, 4'h0, 3'd1, 16'h3000, 1'b0, 3'd2);
        add(4'h1, 4'h7, 1'b0, 1'b0, 4'h0, 3'd1, 16'h3700, 1'b0, 3'd1);
        add(4'h4, 4'h0, 1'b0, 1'b0, 4'h0, 3'd1, 16'h3700, 1'b0, 3'd2);
        add(4'h1, 4'h9, 1'b0, 1'b0, 4'h0, 3'd1, 16'h3900, 1'b0, 3'd1);
        add(4'h1, 4'h5, 1'b0, 1'b0, 4'h0, 3'd1, 16'h3950, 1'b0, 3'd0);
        add(4'h1, 4'hC, 1'b0, 1'b0, 4'h0, 3'd2, 16'h395C, 1'b1, 3'd0);

        foreach (vq[i]) begin
            switch = vq[i].sw; button = vq[i].btn; instr_ready = vq[i].rdy;
            result_valid = vq[i].rv; result = vq[i].res;
            tick();
            button = 4'h0; result_valid = 1'b0; instr_ready = 1'b0;
            chk($sformatf("v%0d_pst", i), {29'h0, pst}, {29'h0, vq[i].e_pst});
            chk($sformatf("v%0d_instr", i), {16'h0, instr}, {16'h0, vq[i].e_instr});
            chk($sformatf("v%0d_valid", i), {31'h0, instr_valid}, {31'h0, vq[i].e_valid});
            chk($sformatf("v%0d_fidx", i), {29'h0, field_idx}, {29'h0, vq[i].e_fidx});
        end

        // ISSUE backpressure: offer must hold steady.
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("hold_valid", {31'h0, instr_valid}, 32'd1);
            chk("hold_instr", {16'h0, instr}, 32'h395C);
        end
        chk_disp("issue", G_3, G_9, G_5, G_C);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("hs_pst", {29'h0, pst}, 32'd3);
        chk("hs_valid", {31'h0, instr_valid}, 32'd0);

        result = 4'h7; result_valid = 1'b1;
        tick();
        result_valid = 1'b0; result = 4'h0;
        chk("cap_pst", {29'h0, pst}, 32'd4);
        chk_disp("res", G_7, G_BLK, G_BLK, G_BLK);
        press(4'h2, 4'h0);
        chk_disp("view1", G_3, G_9, G_5, G_C);
        press(4'h2, 4'h0);
        chk_disp("view0", G_7, G_BLK, G_BLK, G_BLK);
        press(4'h1, 4'h0);
        chk("done_exit_pst", {29'h0, pst}, 32'd0);
        chk_disp("idle", G_0, G_0, G_0, G_0);

        // ENTRY display: committed, live, blank; then abort beats commit.
        press(4'h1, 4'h0);
        press(4'h1, 4'h3);
        switch = 4'h6;
        chk_disp("entry", G_3, G_6, G_BLK, G_BLK);
        press(4'h9, 4'h1);
        chk("prio_pst", {29'h0, pst}, 32'd0);
        chk("prio_instr", {16'h0, instr}, 32'h0);

        // Drive a fresh instruction into WAIT for the timeout behaviour.
        press(4'h1, 4'h0);
        for (int f = 0; f < 4; f++) press(4'h1, 4'h1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("to_wait", {29'h0, pst}, 32'd3);
`ifdef IO_RESULT_TIMEOUT_EN
        for (int c = 0; c < 15; c++) tick();
        chk("to_still_wait", {29'h0, pst}, 32'd3);
        chk("to_err_low", {31'h0, err}, 32'd0);
        tick();
        chk("to_done", {29'h0, pst}, 32'd4);
        chk("to_err", {31'h0, err}, 32'd1);
        chk_disp("to_e", G_E, G_E, G_E, G_E);
        press(4'h1, 4'h0);
        chk("to_clear", {31'h0, err}, 32'd0);
`else
        for (int c = 0; c < 1000; c++) tick();
        chk("no_to_wait", {29'h0, pst}, 32'd3);
        chk("no_to_err", {31'h0, err}, 32'd0);
        press(4'h8, 4'h0);
        chk("no_to_abort", {29'h0, pst}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
